// File: rtl/rs_ff_pkg.sv
// Shared encodings and next-state helper for the RS flip-flop bank.
// Holds the S=R=1 policy codes used by every rs_ff_bit cell.
package rs_ff_pkg;

  localparam int unsigned RS_ILL_HOLD   = 0;
  localparam int unsigned RS_ILL_RST    = 1;
  localparam int unsigned RS_ILL_SET    = 2;
  localparam int unsigned RS_ILL_TOGGLE = 3;

  // Next q for one bit; codes above 3 fall back to hold.
  function automatic logic rs_next(
    input logic        q,
    input logic        s,
    input logic        r,
    input int unsigned mode
  );
    logic n;
    n = q;
    unique case (1'b1)
      (!s && !r): n = q;
      ( s && !r): n = 1'b1;
      (!s &&  r): n = 1'b0;
      default: begin
        unique case (1'b1)
          (mode == RS_ILL_RST):    n = 1'b0;
          (mode == RS_ILL_SET):    n = 1'b1;
          (mode == RS_ILL_TOGGLE): n = ~q;
          default:                 n = q;
        endcase
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rs_ff_bit.sv
// Single RS storage bit with registered S=R=1 flag.
// Ports: clk, reset (sync, active-low), s, r in; q, illegal out.
module rs_ff_bit
  import rs_ff_pkg::*;
#(
  parameter int unsigned ILLEGAL_MODE = RS_ILL_HOLD
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q,
  output logic illegal
);

  logic r_q;
  logic r_ill;
  logic w_q_nxt;
  logic w_ill_nxt;

  always_comb begin
    w_q_nxt   = rs_next(r_q, s, r, ILLEGAL_MODE);
    w_ill_nxt = s & r;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q   <= 1'b0;
      r_ill <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_ill <= w_ill_nxt;
    end
  end

  assign q       = r_q;
  assign illegal = r_ill;

endmodule

// File: rtl/rs_flipflop.sv
// Bank of WIDTH independent clocked RS bits, complementary outputs.
// Ports: clk, reset (sync, active-low), R, S in; q, qbar, illegal out.
module rs_flipflop
  import rs_ff_pkg::*;
#(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned ILLEGAL_MODE = RS_ILL_HOLD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] illegal
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_ill;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    rs_ff_bit #(
      .ILLEGAL_MODE(ILLEGAL_MODE)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .s      (S[g]),
      .r      (R[g]),
      .q      (w_q[g]),
      .illegal(w_ill[g])
    );
  end

  assign q       = w_q;
  assign qbar    = ~w_q;
  assign illegal = w_ill;

endmodule

// File: tb/tb_rs_flipflop.sv
// Directed bench: five 4-bit banks, one per S=R=1 policy
// (modes 0..3 plus out-of-range code 5, which must act as hold).
module tb_rs_flipflop;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] R;
  logic [3:0] S;
  logic [3:0] q   [5];
  logic [3:0] qb  [5];
  logic [3:0] ill [5];

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    rs_flipflop #(
      .WIDTH       (4),
      .ILLEGAL_MODE((g == 4) ? 5 : g)
    ) dut (
      .clk    (clk),
      .reset  (reset),
      .R      (R),
      .S      (S),
      .q      (q[g]),
      .qbar   (qb[g]),
      .illegal(ill[g])
    );
  end

  task automatic chk(input string tag, input int m,
                     input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s mode%0d: got %b want %b", tag, m, obs, exp);
    end
  endtask

  // e0..e3 expected q per mode; code 5 must match hold (e0)
  task automatic chkall(input string tag,
                        input logic [3:0] e0, input logic [3:0] e1,
                        input logic [3:0] e2, input logic [3:0] e3,
                        input logic [3:0] eill);
    logic [3:0] e [5];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e0;
    for (int m = 0; m < 5; m++) begin
      chk({tag, ".q"},    m, q[m],   e[m]);
      chk({tag, ".qbar"}, m, qb[m],  ~e[m]);
      chk({tag, ".ill"},  m, ill[m], eill);
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] s,
                      input logic [3:0] r);
    @(negedge clk);
    reset = rst;
    S = s;
    R = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    S = 4'h0;
    R = 4'h0;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step(1'b0, {v[0], v[1], v[0], v[2]}, {v[1], v[0], v[2], v[0]});
      chkall("rst_low", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    step(1'b0, 4'hF, 4'hF);
    chkall("rst_low_11", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    step(1'b1, 4'b0001, 4'b0000);
    chkall("set", 4'h1, 4'h1, 4'h1, 4'h1, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'h0, 4'h0);
      chkall("hold", 4'h1, 4'h1, 4'h1, 4'h1, 4'h0);
    end
    step(1'b1, 4'b0000, 4'b0001);
    chkall("clear", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    @(negedge clk);
    #2 S = 4'hF;
    #3 S = 4'h0;
    @(posedge clk);
    #1;
    chkall("glitch", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    step(1'b1, 4'b0101, 4'b1010);
    chkall("bank", 4'h5, 4'h5, 4'h5, 4'h5, 4'h0);

    step(1'b1, 4'hF, 4'h0);
    chkall("setall", 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
    step(1'b1, 4'hF, 4'hF);
    chkall("forbid1", 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
    step(1'b1, 4'hF, 4'hF);
    chkall("forbid2", 4'hF, 4'h0, 4'hF, 4'hF, 4'hF);
    step(1'b1, 4'h0, 4'h0);
    chkall("ill_clr", 4'hF, 4'h0, 4'hF, 4'hF, 4'h0);

    step(1'b1, 4'b1100, 4'b1010);
    chkall("mixed", 4'b1101, 4'b0100, 4'b1101, 4'b0101, 4'b1000);

    step(1'b0, 4'hF, 4'h0);
    chkall("rst_prio", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    step(1'b1, 4'b0010, 4'b0000);
    chkall("deassert", 4'h2, 4'h2, 4'h2, 4'h2, 4'h0);

    step(1'b1, 4'hF, 4'hF);
    chkall("forbid3", 4'h2, 4'h0, 4'hF, 4'hD, 4'hF);
    step(1'b0, 4'hF, 4'hF);
    chkall("rst_mid", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
